// File: rtl/dequant_pkg.sv
// Shared definitions for the lab3 requantize/dequantize pair.
//   DW     : sample width
//   NQW    : width of the Nquant control word
//   NQ_MIN : smallest supported code width
//   state_t: sequencer states of the iterative dequantizer
//   clamp_nq: limits an Nquant control word to NQ_MIN..DW
package dequant_pkg;

  localparam int DW     = 18;
  localparam int NQW    = 5;
  localparam int NQ_MIN = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } state_t;

  function automatic logic [NQW-1:0] clamp_nq(input logic [NQW-1:0] nq);
    if (nq < NQW'(NQ_MIN))
      return NQW'(NQ_MIN);
    else if (nq > NQW'(DW))
      return NQW'(DW);
    else
      return nq;
  endfunction

endpackage

// File: rtl/dequantize_sext.sv
// Combinational sign extension of a right-aligned code.
//   code  : code in bits [nq-1:0]; upper bits ignored
//   nq    : effective code width, already clamped to NQ_MIN..DW
//   value : code sign-extended from bit nq-1 to DW bits
module dequantize_sext
  import dequant_pkg::*;
(
  input  logic [DW-1:0]  code,
  input  logic [NQW-1:0] nq,
  output logic [DW-1:0]  value
);

  logic [NQW-1:0] sh;
  logic [DW-1:0]  up;

  // Push the code's sign bit to the MSB, then shift back arithmetically;
  // this both discards the ignored upper bits and replicates the sign.
  assign sh    = NQW'(DW) - nq;
  assign up    = code << sh;
  assign value = $signed(up) >>> sh;

endmodule

// File: rtl/dequantize.sv
// Iterative dequantizer: reconstructs a DW-bit sample at the midpoint of
// the quantization step from an Nquant-bit two's-complement code, using
// one left shift per clock.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   Nquant    : code width (clamped to NQ_MIN..DW), captured at load
//   datain    : code right-aligned in [Nquant-1:0], captured at load
//   endatain  : start pulse, honoured only in IDLE
//   dataout   : reconstructed sample, held until the next result
//   dataready : one-cycle pulse when dataout is new
//   busy      : high while an operation is in progress
module dequantize
  import dequant_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic [NQW-1:0] Nquant,
  input  logic [DW-1:0]  datain,
  input  logic           endatain,
  output logic [DW-1:0]  dataout,
  output logic           dataready,
  output logic           busy
);

  state_t         state, state_next;
  logic [DW-1:0]  acc;
  logic [DW-1:0]  sext_val;
  logic [DW-1:0]  off;
  logic [NQW-1:0] cnt;
  logic [NQW-1:0] nq;
  logic [NQW-1:0] nq_eff;
  logic [NQW-1:0] load_cnt;

  assign nq_eff   = clamp_nq(Nquant);
  assign load_cnt = NQW'(DW) - nq_eff;

  dequantize_sext u_sext (
    .code  (datain),
    .nq    (nq_eff),
    .value (sext_val)
  );

  // Half-step rounding offset; a full-width code has no fractional step.
  always_comb begin
    off = '0;
    if (nq < NQW'(DW))
      off = DW'(1) << (NQW'(DW - 1) - nq);
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (endatain) state_next = (load_cnt != '0) ? SHIFT : FINISH;
      SHIFT:   if (cnt == NQW'(1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      nq        <= '0;
      dataout   <= '0;
      dataready <= 1'b0;
    end else begin
      dataready <= 1'b0;
      case (state)
        IDLE: begin
          if (endatain) begin
            acc <= sext_val;
            cnt <= load_cnt;
            nq  <= nq_eff;
          end
        end
        SHIFT: begin
          acc <= {acc[DW-2:0], 1'b0};
          cnt <= cnt - NQW'(1);
        end
        FINISH: begin
          dataout   <= acc + off;
          dataready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dequantize.sv
module tb_dequantize;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  Nquant;
  logic [17:0] datain;
  logic        endatain;
  logic [17:0] dataout;
  logic        dataready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dequantize dut (
    .clock     (clock),
    .reset     (reset),
    .Nquant    (Nquant),
    .datain    (datain),
    .endatain  (endatain),
    .dataout   (dataout),
    .dataready (dataready),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int nq);
    if (nq < 2) return 2;
    if (nq > 18) return 18;
    return nq;
  endfunction

  // Reference: signed code value scaled to 18 bits plus half a step.
  function automatic logic [17:0] ref_out(input int nq, input logic [17:0] din);
    int n;
    longint code;
    longint r;
    n = eff(nq);
    code = longint'(din) % (longint'(1) << n);
    if (code >= (longint'(1) << (n - 1))) code = code - (longint'(1) << n);
    r = code * (longint'(1) << (18 - n));
    if (n < 18) r = r + (longint'(1) << (17 - n));
    return 18'(r);
  endfunction

  // Presents a load request and returns 1 time unit after the load edge;
  // inputs are then scrambled to show they are not re-sampled.
  task automatic start(input int nq, input logic [17:0] din);
    Nquant   = 5'(nq);
    datain   = din;
    endatain = 1'b1;
    @(posedge clock); #1;
    endatain = 1'b0;
    Nquant   = 5'($urandom);
    datain   = 18'($urandom);
  endtask

  task automatic wait_result(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (dataready !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic finish_checks(input string tag, input int nq, input logic [17:0] exp,
                               input int edges, input int busy_cnt);
    int s;
    s = 18 - eff(nq);
    check({tag, " ready"}, 32'(dataready), 32'd1);
    check({tag, " dataout"}, 32'(dataout), 32'(exp));
    check({tag, " latency"}, 32'(edges), 32'(s + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(s + 1));
    check({tag, " busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic do_op(input string tag, input int nq, input logic [17:0] din,
                       input logic [17:0] exp);
    int e, b;
    @(negedge clock);
    start(nq, din);
    wait_result(e, b);
    finish_checks(tag, nq, exp, e, b);
    @(posedge clock); #1;
    check({tag, " pulse_end"}, 32'(dataready), 32'd0);
  endtask

  initial begin
    int e, b, n, cnt_ready;
    logic [17:0] d;

    reset = 1'b1; Nquant = '0; datain = '0; endatain = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst dataout", 32'(dataout), 32'd0);
    check("rst dataready", 32'(dataready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clock); reset = 1'b0;

    do_op("nq2 pos", 2, 18'h00001, 18'h18000);
    do_op("nq2 neg", 2, 18'h00002, 18'h28000);
    do_op("nq2 upper", 2, 18'h3FFFE, 18'h28000);
    do_op("nq10", 10, 18'h003FF, 18'h3FF80);
    do_op("nq7", 7, 18'd24, 18'h0C400);
    do_op("nq18", 18, 18'h2A5A5, 18'h2A5A5);
    do_op("nq0", 0, 18'h00001, 18'h18000);
    do_op("nq25", 25, 18'h2A5A5, 18'h2A5A5);

    // endatain while busy must be ignored and not queued.
    @(negedge clock);
    start(2, 18'h00001);
    repeat (3) @(posedge clock);
    @(negedge clock);
    Nquant = 5'd5; datain = 18'h00002; endatain = 1'b1;
    @(posedge clock); #1;
    endatain = 1'b0;
    wait_result(e, b);
    check("ignore ready", 32'(dataready), 32'd1);
    check("ignore dataout", 32'(dataout), 32'h18000);
    check("ignore latency", 32'(e), 32'd13);
    repeat (3) begin
      @(posedge clock); #1;
      check("ignore no_queue", 32'(busy), 32'd0);
    end

    // Back-to-back: new load in the dataready cycle.
    @(negedge clock);
    start(7, 18'd24);
    wait_result(e, b);
    finish_checks("b2b first", 7, 18'h0C400, e, b);
    start(10, 18'h003FF);
    wait_result(e, b);
    finish_checks("b2b second", 10, 18'h3FF80, e, b);

    // Reset mid-operation aborts without a result pulse.
    @(negedge clock);
    start(2, 18'h00001);
    repeat (4) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort dataout", 32'(dataout), 32'd0);
    check("abort dataready", 32'(dataready), 32'd0);
    @(negedge clock); reset = 1'b0;
    cnt_ready = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (dataready === 1'b1) cnt_ready++;
    end
    check("abort no_pulse", 32'(cnt_ready), 32'd0);
    do_op("after abort", 2, 18'h00002, 18'h28000);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 20; i++) begin
      n = int'($urandom_range(0, 31));
      d = 18'($urandom);
      do_op($sformatf("rand%0d n=%0d d=%0h", i, n, d), n, d, ref_out(n, d));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
